// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 audio clock generator.
// Optional MCLK output is enabled with WM8731_CLKGEN_MCLK_EN.
package wm8731_pkg;

    localparam logic MODE_I2S = 1'b1;
    localparam logic MODE_PCM = 1'b0;

    localparam int BITS_PER_FRAME_DEF = 64;
    localparam int BCLK_HALF_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } clkgen_state_t;

    // LRCK level for bit slot b of a frame of bpf slots
    function automatic logic lrck_of(
        input int unsigned b,
        input logic        mode,
        input int unsigned bpf
    );
        if (mode == MODE_I2S)
            return (b >= bpf / 2);
        else
            return (b == 0);
    endfunction

endpackage

// File: rtl/wm8731_clkdiv.sv
// Enable-gated toggle divider: level flips every HALF enabled cycles.
// Rise/fall strobes are high in the cycle before the level changes.
module wm8731_clkdiv #(
    parameter int HALF = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick   = i_en && (cnt == LAST);
    assign o_rise = tick & ~o_level;
    assign o_fall = tick & o_level;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt     <= '0;
            o_level <= 1'b0;
        end else if (i_en) begin
            if (tick) begin
                cnt     <= '0;
                o_level <= ~o_level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wm8731_clkgen.sv
// Master-mode MCLK/BCLK/LRCK generator with frame-aligned start/stop.
// Define WM8731_CLKGEN_MCLK_EN to enable the free-running MCLK divider.
module wm8731_clkgen
    import wm8731_pkg::*;
#(
    parameter int BCLK_HALF      = BCLK_HALF_DEF,
    parameter int BITS_PER_FRAME = BITS_PER_FRAME_DEF,
    parameter int MCLK_DIV       = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_en,
    input  logic                              i_mode,
    output logic                              o_mclk,
    output logic                              o_bclk,
    output logic                              o_lrck,
    output logic                              o_frame_start,
    output logic [$clog2(BITS_PER_FRAME)-1:0] o_bit_idx,
    output logic                              o_busy
);

    localparam int BW = $clog2(BITS_PER_FRAME);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_FRAME - 1);

    clkgen_state_t state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          mode_q, mode_d;
    logic          lrck_q, lrck_d;
    logic          fs_q, fs_d;
    logic          clr;
    logic          bclk_rise, bclk_fall;
    logic          unused_strobes;

    wm8731_clkdiv #(.HALF(BCLK_HALF)) u_bclk_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (state_q != ST_IDLE),
        .i_clr   (clr),
        .o_level (o_bclk),
        .o_rise  (bclk_rise),
        .o_fall  (bclk_fall)
    );

`ifdef WM8731_CLKGEN_MCLK_EN
    logic mclk_rise, mclk_fall;

    wm8731_clkdiv #(.HALF(MCLK_DIV / 2)) u_mclk_div (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (1'b1),
        .i_clr   (1'b0),
        .o_level (o_mclk),
        .o_rise  (mclk_rise),
        .o_fall  (mclk_fall)
    );

    assign unused_strobes = bclk_rise ^ mclk_rise ^ mclk_fall;
`else
    localparam int MCLK_HALF_UNUSED = MCLK_DIV / 2;

    assign o_mclk         = 1'b0;
    assign unused_strobes = bclk_rise;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        mode_d  = mode_q;
        lrck_d  = lrck_q;
        fs_d    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                clr    = 1'b1;
                bit_d  = '0;
                lrck_d = 1'b0;
                if (i_en) begin
                    state_d = ST_RUN;
                    mode_d  = i_mode;
                    fs_d    = 1'b1;
                    lrck_d  = lrck_of(0, i_mode, BITS_PER_FRAME);
                end
            end
            ST_RUN, ST_DRAIN: begin
                state_d = i_en ? ST_RUN : state_q;
                if (state_q == ST_RUN && !i_en)
                    state_d = ST_DRAIN;
                if (bclk_fall) begin
                    if (bit_q != LAST_BIT) begin
                        bit_d  = bit_q + BW'(1);
                        lrck_d = lrck_of(32'(bit_q) + 1, mode_q,
                                         BITS_PER_FRAME);
                    end else if (state_q == ST_DRAIN && !i_en) begin
                        // Stop at the frame boundary with both clocks low
                        state_d = ST_IDLE;
                        bit_d   = '0;
                        lrck_d  = 1'b0;
                        clr     = 1'b1;
                    end else begin
                        bit_d  = '0;
                        mode_d = i_mode;
                        fs_d   = 1'b1;
                        lrck_d = lrck_of(0, i_mode, BITS_PER_FRAME);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            mode_q  <= MODE_I2S;
            lrck_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            mode_q  <= mode_d;
            lrck_q  <= lrck_d;
            fs_q    <= fs_d;
        end
    end

    assign o_lrck        = lrck_q;
    assign o_frame_start = fs_q;
    assign o_bit_idx     = bit_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule
